uart_tx_arbiter: RTL

//   Shares one uart_tx transmitter between N byte-stream requesters (watch, stopwatch, HC-SR04, DHT-11 report formatters).

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the uart_tx transmitter and the
// arbiter that shares it. The arbiter connects through the slave modport.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               start_trigger;
   logic [7:0]         tx_data;
   logic               tx_busy;
   logic               abort;

   // Handshake: byte i (req_data[8i+7:8i], flag req_last[i]) transfers on any
   // posedge where req_valid[i] & req_ready[i]; a requester keeps byte and
   // flag stable while req_valid[i] is high and the byte is not yet taken.
   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, grant, start_trigger, tx_data, abort
   );
   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, grant, start_trigger, tx_data, abort
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter in front of a single uart_tx. The owner
// keeps the transmitter until its 'last' byte has left the UART, or until it
// stalls in LOAD for LOCK_TIMEOUT cycles, which drops the lock with an abort.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int LOCK_TIMEOUT = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus,
   output logic [2:0]       dbg_state
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

   state_t           state, state_nx;
   logic [N_REQ-1:0] grant_q, grant_nx;
   logic [IW-1:0]    owner_q, owner_nx;
   logic [IW-1:0]    rr_ptr, rr_ptr_nx;
   logic [7:0]       tx_data_q, tx_data_nx;
   logic             last_reg, last_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             start_q, start_nx;
   logic             abort_q, abort_nx;

   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [IW-1:0]    cand;
   logic [IW-1:0]    owner_inc;
   logic             accept;

   // Index 'base + k' wrapped into 0..N_REQ-1.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IW'(s);
   endfunction

   assign owner_inc = wrap_add(owner_q, 1);
   assign accept    = (state == LOAD) && bus.req_valid[owner_q];

   // First requesting index at or above rr_ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = wrap_add(rr_ptr, k);
         if (!pick_found && bus.req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and next-register values for the message sequencer.
   always_comb begin
      state_nx   = state;
      grant_nx   = grant_q;
      owner_nx   = owner_q;
      rr_ptr_nx  = rr_ptr;
      tx_data_nx = tx_data_q;
      last_nx    = last_reg;
      cnt_nx     = cnt;
      start_nx   = 1'b0;
      abort_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_nx = ONE << pick_idx;
               owner_nx = pick_idx;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               tx_data_nx = bus.req_data[{owner_q, 3'b000} +: 8];
               last_nx    = bus.req_last[owner_q];
               cnt_nx     = '0;
               state_nx   = START;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               // Owner stalled mid-message: drop the lock and move on.
               abort_nx  = 1'b1;
               grant_nx  = '0;
               rr_ptr_nx = owner_inc;
               cnt_nx    = '0;
               state_nx  = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         START: begin
            // Never pulse into a transmitter that is still busy.
            if (!bus.tx_busy) begin
               start_nx = 1'b1;
               state_nx = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (bus.tx_busy) state_nx = WAIT_LO;
         end
         WAIT_LO: begin
            if (!bus.tx_busy) begin
               if (last_reg) begin
                  grant_nx  = '0;
                  rr_ptr_nx = owner_inc;
                  state_nx  = IDLE;
               end else begin
                  state_nx = LOAD;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr    <= '0;
         tx_data_q <= 8'h00;
         last_reg  <= 1'b0;
         cnt       <= '0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         grant_q   <= grant_nx;
         owner_q   <= owner_nx;
         rr_ptr    <= rr_ptr_nx;
         tx_data_q <= tx_data_nx;
         last_reg  <= last_nx;
         cnt       <= cnt_nx;
         start_q   <= start_nx;
         abort_q   <= abort_nx;
      end
   end

   assign bus.req_ready     = (state == LOAD) ? grant_q : '0;
   assign bus.grant         = grant_q;
   assign bus.start_trigger = start_q;
   assign bus.tx_data       = tx_data_q;
   assign bus.abort         = abort_q;
   assign dbg_state         = state;
endmodule
